// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, frame size and
// default timing constants.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP,
        ST_HOLD,
        ST_RECOVER
    } spi_state_e;

    localparam int SPI_BYTES    = 2;
    localparam int SPI_BITS     = 8 * SPI_BYTES;
    localparam int DEF_HALF_DIV = 8;
    localparam int DEF_GAP      = 16;
    localparam int TICK_W       = 8;

endpackage

// File: rtl/spi_tick_gen.sv
// Loadable down-counter; tick is high while the count sits at zero, marking
// the last clk cycle of the current phase.
module spi_tick_gen
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    output logic              tick
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Two-byte SPI master (CPOL=0, CPHA=0): sends {addr, wdata}, returns the
// second received byte. Optional lpbk input under SPI_MASTER_LOOPBACK_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV = DEF_HALF_DIV,
    parameter int GAP      = DEF_GAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic       lpbk,
`endif
    input  logic       miso
);

    localparam logic [TICK_W-1:0] HALF_LD  = TICK_W'(HALF_DIV - 1);
    localparam logic [TICK_W-1:0] GAP_LD   = TICK_W'(GAP - 1);
    localparam logic [4:0]        LAST_BIT = 5'(SPI_BITS);
    localparam logic [4:0]        MID_BIT  = 5'(SPI_BITS / 2);

    spi_state_e state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [SPI_BITS-1:0] tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                cs_q, cs_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tick_load;
    logic [TICK_W-1:0]   tick_val;
    logic                tick;
    logic                sample;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample = lpbk ? mosi_q : miso;
`else
    assign sample = miso;
`endif

    spi_tick_gen u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tick_load),
        .load_val (tick_val),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tick_load = 1'b0;
        tick_val  = HALF_LD;

        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    tx_d      = {addr, wdata};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    cs_d      = 1'b0;
                    mosi_d    = addr[7];
                    tick_load = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tick) begin
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[6:0], sample};
                    cnt_d     = cnt_q + 5'd1;
                    tick_load = 1'b1;
                    state_d   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    tick_load = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        sck_d   = 1'b0;
                        mosi_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else if (cnt_q == MID_BIT && GAP > 0) begin
                        tick_val = GAP_LD;
                        state_d  = ST_GAP;
                    end else begin
                        sck_d   = 1'b0;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[SPI_BITS-2];
                        state_d = ST_LOW;
                    end
                end
            end
            ST_GAP: begin
                // sck stays high across the byte gap; next bit is wdata[7].
                if (tick) begin
                    sck_d     = 1'b0;
                    tx_d      = tx_q << 1;
                    mosi_d    = tx_q[SPI_BITS-2];
                    tick_load = 1'b1;
                    state_d   = ST_LOW;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_d      = 1'b1;
                    tick_load = 1'b1;
                    state_d   = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = rx_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign cs    = cs_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_DIV, default 8, meaning clk cycles per sck half-period; legal range 2..255.
REQ-002 Parameter GAP, default 16, meaning extra clk cycles sck is held high after the 8th rising edge; legal range 0..255.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle transaction request, accepted only in IDLE.
REQ-006 addr  input  8  first byte sent (register address).
REQ-007 wdata  input  8  second byte sent (write data).
REQ-008 busy  output  1  high from the cycle after acceptance until done.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rdata  output  8  miso bits captured during the second byte.
REQ-011 cs  output  1  SPI chip select, active low.
REQ-012 sck  output  1  SPI clock, CPOL=0.
REQ-013 mosi  output  1  master-out, MSB first.
REQ-014 miso  input  1  slave-out, sampled on sck rising edge (CPHA=0).

Function
REQ-015 FSM states: IDLE, SETUP, LOW, HIGH, GAP, HOLD, RECOVER; all outputs registered.
REQ-016 IDLE with start=1: latch {addr,wdata} into a 16-bit shift register, clear bit counter; next cycle busy=1, cs=0, mosi=addr[7], enter SETUP.
REQ-017 SETUP lasts HALF_DIV cycles with sck=0, then HIGH.
REQ-018 Entering HIGH: sck=1, miso sampled into rdata shift register on this same clk edge, bit counter +1; HIGH lasts HALF_DIV cycles.
REQ-019 Leaving HIGH with count<16: sck=0, mosi=next bit, enter LOW (HALF_DIV cycles), then HIGH; exception count==8 and GAP>0 -> GAP state.
REQ-020 GAP: sck stays 1 for GAP further cycles, then proceeds as REQ-019 (mosi=wdata[7]).
REQ-021 Leaving HIGH with count==16: sck=0, mosi=0, enter HOLD (HALF_DIV cycles), then cs=1, enter RECOVER (HALF_DIV cycles), then IDLE.
REQ-022 done=1 and rdata updated with the final 8 captured bits on the RECOVER->IDLE cycle; busy falls the same cycle.
REQ-023 Only bits 9..16 go into rdata; bits 1..8 are discarded.
REQ-024 start while not IDLE is ignored; start on the done cycle is ignored; start the cycle after done is accepted.
REQ-025 Exactly 16 rising sck edges per transaction; sck=0 whenever cs=1.
REQ-026 Transaction length with HALF_DIV=H, GAP=G: 1 + 34*H + G cycles from start to done.

Reset
REQ-027 rst_n low: cs=1, sck=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE, counters cleared.
REQ-028 Reset mid-transaction aborts immediately: cs=1 asynchronously, no done pulse, rdata=0.

Configuration
REQ-029 Macro SPI_MASTER_LOOPBACK_EN defined: add input port lpbk (1 bit); when lpbk=1 the sampled value is mosi, not miso; cs/sck timing unchanged.
REQ-030 Macro undefined: no lpbk port; miso always sampled.

Structure
REQ-031 Shared package spi_pkg holds the FSM state enum, SPI_BYTES=2, default HALF_DIV/GAP constants.
REQ-032 One sub-module spi_tick_gen: loadable down-counter producing a one-cycle phase-end tick; FSM lives in spi_master.

Verification
REQ-033 HALF_DIV=8, GAP=16, addr=0x5A, wdata=0xC3, slave model returns 0x96 -> mosi 0x5A then 0xC3, rdata=0x96, done at cycle 1+272+16=289.
REQ-034 Back-to-back: start the cycle after done with addr=0x01 -> accepted; cs high for >=8 cycles between frames.
REQ-035 start pulsed mid-transaction -> ignored; exactly 16 sck rising edges, single done.
REQ-036 rst_n asserted after the 5th sck rising edge -> cs=1, sck=0 immediately, no done, rdata=0x00.
REQ-037 HALF_DIV=2, GAP=0, miso tied 1 -> rdata=0xFF, done at cycle 69.
REQ-038 SPI_MASTER_LOOPBACK_EN, lpbk=1, wdata=0xA5 -> rdata=0xA5.
